// File: rtl/seq_divider_nxn.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock under start/done.
// done/results appear N+1 edges after start is accepted (1 edge for divide-by-zero); start is ignored while running.
module seq_divider_nxn #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [N:0]    acc, acc_step, shifted, trial;
  logic [N-1:0]  q_reg, q_step, d_reg;
  logic [CW-1:0] count;
  logic          dbz;
  logic          last_step;

  assign last_step = (count == CW'(N - 1));

  // One restoring step: shift {acc,Q} left, keep the trial difference only if it did not borrow.
  always_comb begin
    shifted  = {acc[N-1:0], q_reg[N-1]};
    trial    = shifted - {1'b0, d_reg};
    acc_step = trial[N] ? shifted : trial;
    q_step   = {q_reg[N-2:0], ~trial[N]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      count       <= '0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == DONE);
      // busy stays up through the cycle in which done is presented.
      busy <= (state_nxt != IDLE) || (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            acc   <= '0;
            count <= '0;
            dbz   <= (divisor == '0);
          end
        end
        RUN: begin
          acc   <= acc_step;
          q_reg <= q_step;
          count <= count + CW'(1);
        end
        DONE: begin
          // On divide-by-zero q_reg still holds the untouched dividend.
          quotient    <= dbz ? {N{1'b1}} : q_reg;
          remainder   <= dbz ? q_reg : acc[N-1:0];
          div_by_zero <= dbz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_nxn.sv
// Directed-vector and randomized check of seq_divider_nxn at N=8.
module tb_seq_divider_nxn;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider_nxn #(.N(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Launch one division, scramble the operand inputs after acceptance, and measure.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                        output logic [7:0] q, output logic [7:0] r, output logic z,
                        output logic stable, output logic run_busy,
                        output logic tail_done, output logic tail_busy);
    logic [7:0] pq, pr;
    pq = quotient;
    pr = remainder;
    stable = 1'b1;
    run_busy = 1'b0;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = ~a;
    divisor = ~b;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) run_busy = busy;
      if (done) begin
        lat = k;
        break;
      end
      if (quotient !== pq || remainder !== pr) stable = 1'b0;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    @(negedge clk);
    tail_done = done;
    tail_busy = busy;
  endtask

  initial begin
    vec_t vecs[8];
    int lat;
    logic [7:0] q, r;
    logic z, stable, run_busy, tail_done, tail_busy;
    logic saw_done;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  z: 1'b0, lat: 9};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  z: 1'b0, lat: 9};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  z: 1'b0, lat: 9};
    vecs[3] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  z: 1'b0, lat: 9};
    vecs[4] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  z: 1'b0, lat: 9};
    vecs[5] = '{a: 8'd37,  b: 8'd0,   q: 8'd255, r: 8'd37, z: 1'b1, lat: 1};
    vecs[6] = '{a: 8'd37,  b: 8'd5,   q: 8'd7,   r: 8'd2,  z: 1'b0, lat: 9};
    vecs[7] = '{a: 8'd13,  b: 8'd13,  q: 8'd1,   r: 8'd0,  z: 1'b0, lat: 9};

    #12;
    chk("reset_outputs", {busy, done, div_by_zero, quotient, remainder}, '0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, q, r, z, stable, run_busy, tail_done, tail_busy);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_quotient", i), {24'd0, q}, {24'd0, vecs[i].q});
      chk($sformatf("v%0d_remainder", i), {24'd0, r}, {24'd0, vecs[i].r});
      chk($sformatf("v%0d_dbz", i), {31'd0, z}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_busy_running", i), {31'd0, run_busy}, 32'd1);
      chk($sformatf("v%0d_stable_before_done", i), {31'd0, stable}, 32'd1);
      chk($sformatf("v%0d_done_one_cycle", i), {31'd0, tail_done}, 32'd0);
      chk($sformatf("v%0d_busy_after_done", i), {31'd0, tail_busy}, 32'd0);
    end

    // start pulsed mid-run with other operands must be ignored
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start = 1'b1;
        dividend = 8'd9;
        divisor = 8'd2;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("ignored_start_latency", lat, 9);
    chk("ignored_start_quotient", {24'd0, quotient}, 32'd66);
    chk("ignored_start_remainder", {24'd0, remainder}, 32'd2);
    @(negedge clk);
    chk("ignored_start_idle_after", {30'd0, busy, done}, 32'd0);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrun_reset_busy", {31'd0, busy}, 32'd0);
    chk("midrun_reset_results", {8'd0, quotient, remainder, 7'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("midrun_reset_no_done", {31'd0, saw_done}, 32'd0);

    // randomized operands against the division identity
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a, b;
      int qi, ri;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op(a, b, lat, q, r, z, stable, run_busy, tail_done, tail_busy);
      qi = int'(q);
      ri = int'(r);
      chk("rnd_identity", qi * int'(b) + ri, int'(a));
      chk("rnd_rem_lt_div", {31'd0, (ri < int'(b))}, 32'd1);
      chk("rnd_latency", lat, 9);
      chk("rnd_done_width_stable", {30'd0, tail_done, stable}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
